// File: rtl/ei_mac_pkg.sv
// rtl/ei_mac_pkg.sv - shared types and widths for the MAC dot-product sequencer
package ei_mac_pkg;

  localparam int OPW     = 8;
  localparam int ACCW    = 32;
  localparam int DEF_LAT = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    ISSUE  = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

endpackage

// File: rtl/ei_opbuf.sv
// rtl/ei_opbuf.sv - operand register file holding A (high byte) and B (low byte) per entry
module ei_opbuf
  import ei_mac_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [2*OPW-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [2*OPW-1:0] rdata
);

  logic [2*OPW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ei_mac_dot_seq.sv
// rtl/ei_mac_dot_seq.sv - streams buffered operand pairs into a MAC and returns the dot product
module ei_mac_dot_seq
  import ei_mac_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int LW     = $clog2(DEPTH + 1),
  parameter int LAT    = DEF_LAT,
  parameter int TO_CYC = LAT + 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [OPW-1:0]  wr_a,
  input  logic [OPW-1:0]  wr_b,
  input  logic            start,
  input  logic [LW-1:0]   len,
  output logic            busy,
  output logic            mac_valid_in,
  output logic            mac_clr_acc,
  output logic [OPW-1:0]  mac_a,
  output logic [OPW-1:0]  mac_b,
  input  logic [ACCW-1:0] mac_acc_out,
  input  logic            mac_valid_out,
  output logic [ACCW-1:0] res_data,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            err
);

  localparam int DW = $clog2(TO_CYC + 1);

  state_t           state, state_n;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    idx;
  logic [LW-1:0]    ret_cnt;
  logic [DW-1:0]    drain_cnt;
  logic [2*OPW-1:0] rd_word;
  logic             ret_done;
  logic             drain_to;

  ei_opbuf #(.DEPTH(DEPTH), .AW(AW)) u_opbuf (
    .clk   (clk),
    .en    (en),
    .we    (wr_en && (state == IDLE)),
    .waddr (wr_addr),
    .wdata ({wr_a, wr_b}),
    .raddr (idx[AW-1:0]),
    .rdata (rd_word)
  );

  // The final return is accepted in the same cycle its valid_out arrives.
  assign ret_done = mac_valid_out && ((ret_cnt + LW'(1)) == len_q);
  assign drain_to = !ret_done && (drain_cnt == DW'(TO_CYC - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = CLR;
      CLR:     state_n = (len_q == '0) ? RESULT : ISSUE;
      ISSUE:   if (idx == len_q) state_n = DRAIN;
      DRAIN:   if (ret_done || drain_to) state_n = RESULT;
      RESULT:  if (res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len_q        <= '0;
      idx          <= '0;
      ret_cnt      <= '0;
      drain_cnt    <= '0;
      mac_valid_in <= 1'b0;
      mac_clr_acc  <= 1'b0;
      mac_a        <= '0;
      mac_b        <= '0;
      res_data     <= '0;
      res_valid    <= 1'b0;
      err          <= 1'b0;
    end else if (en) begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q       <= len;
            err         <= 1'b0;
            mac_clr_acc <= 1'b1;
            idx         <= '0;
          end
        end
        CLR: begin
          mac_clr_acc <= 1'b0;
          ret_cnt     <= '0;
          drain_cnt   <= '0;
          if (len_q == '0) begin
            res_data  <= '0;
            res_valid <= 1'b1;
          end else begin
            // Entry 0 is preloaded so mac_valid_in is high for exactly len ISSUE cycles.
            mac_valid_in <= 1'b1;
            mac_a        <= rd_word[2*OPW-1:OPW];
            mac_b        <= rd_word[OPW-1:0];
            idx          <= LW'(1);
          end
        end
        ISSUE: begin
          ret_cnt <= ret_cnt + LW'(mac_valid_out);
          if (idx == len_q) begin
            mac_valid_in <= 1'b0;
          end else begin
            mac_a <= rd_word[2*OPW-1:OPW];
            mac_b <= rd_word[OPW-1:0];
            idx   <= idx + LW'(1);
          end
        end
        DRAIN: begin
          ret_cnt   <= ret_cnt + LW'(mac_valid_out);
          drain_cnt <= drain_cnt + DW'(1);
          if (ret_done || drain_to) begin
            res_data  <= mac_acc_out;
            res_valid <= 1'b1;
            err       <= drain_to;
          end
        end
        RESULT: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ei_mac_dot_seq.sv
// tb/tb_ei_mac_dot_seq.sv - self-checking bench for ei_mac_dot_seq with a behavioural MAC stand-in
module tb_ei_mac_dot_seq;

  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int LW     = 5;
  localparam int LAT    = 3;
  localparam int TO_CYC = LAT + 4;

  logic        clk, rst, en, wr_en, start, res_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]  wr_a, wr_b;
  logic [LW-1:0] len;
  logic        busy, mac_valid_in, mac_clr_acc, res_valid, err;
  logic [7:0]  mac_a, mac_b;
  logic [31:0] mac_acc_out, res_data;
  logic        mac_valid_out;

  int checks = 0;
  int failures = 0;

  ei_mac_dot_seq #(.DEPTH(DEPTH), .AW(AW), .LW(LW), .LAT(LAT), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
    .start(start), .len(len), .busy(busy), .mac_valid_in(mac_valid_in), .mac_clr_acc(mac_clr_acc),
    .mac_a(mac_a), .mac_b(mac_b), .mac_acc_out(mac_acc_out), .mac_valid_out(mac_valid_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC stand-in: LAT product stages, accumulate, optional suppression of the final valid_out
  logic [LAT-1:0] pv;
  logic [15:0]    pp [LAT];
  logic [31:0]    macc;
  logic           mvout;
  int             mcnt;
  bit             drop_last = 1'b0;
  int             cur_len = 0;

  always @(posedge clk) begin
    if (rst) begin
      pv    <= '0;
      macc  <= '0;
      mvout <= 1'b0;
      mcnt  <= 0;
    end else if (en) begin
      pv    <= {pv[LAT-2:0], mac_valid_in};
      pp[0] <= 16'(mac_a) * 16'(mac_b);
      for (int i = 1; i < LAT; i++) pp[i] <= pp[i-1];
      mvout <= 1'b0;
      if (mac_clr_acc) begin
        macc <= '0;
        mcnt <= 0;
      end else if (pv[LAT-1]) begin
        macc  <= macc + 32'(pp[LAT-1]);
        mcnt  <= mcnt + 1;
        mvout <= !(drop_last && (mcnt + 1 == cur_len));
      end
    end
  end

  assign mac_acc_out   = macc;
  assign mac_valid_out = mvout;

  logic [7:0] sa [DEPTH];
  logic [7:0] sb [DEPTH];

  function automatic logic [31:0] ref_dot(input int n);
    logic [31:0] s = 0;
    for (int i = 0; i < n; i++) s += 32'(sa[i]) * 32'(sb[i]);
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wr_one(input int ad, input logic [7:0] a, input logic [7:0] b);
    wr_en = 1'b1; wr_addr = AW'(ad); wr_a = a; wr_b = b;
    @(negedge clk);
    wr_en = 1'b0;
    sa[ad] = a; sb[ad] = b;
  endtask

  // mode bit0: stray start/write mid-op and in RESULT; bit1: en stall; bit2: drop last return
  task automatic run_cmd(input int n, input int mode, input int bp,
                         output logic [31:0] r, output logic e);
    int cyc, clr_n, vin_n, t_drain, t_res;
    logic prev_v;
    logic [33:0] snap;
    logic [31:0] hold_d;
    cur_len = n;
    drop_last = mode[2];
    start = 1'b1; len = LW'(n);
    @(negedge clk);
    start = 1'b0;
    chk("err_clear_on_start", 32'(err), 0);
    cyc = 0; clr_n = 0; vin_n = 0; t_drain = -1; t_res = -1; prev_v = 1'b0; snap = '0;
    while (cyc < 100) begin
      if (en) begin
        clr_n += int'(mac_clr_acc);
        vin_n += int'(mac_valid_in);
      end
      if (prev_v && !mac_valid_in && t_drain < 0) t_drain = cyc;
      prev_v = mac_valid_in;
      if (res_valid) begin
        t_res = cyc;
        break;
      end
      if (mode[0] && cyc == 2) begin
        start = 1'b1; len = LW'(1); wr_en = 1'b1; wr_addr = '0; wr_a = 8'd99; wr_b = 8'd99;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      if (mode[1]) begin
        if (cyc == 2) begin
          snap = {busy, mac_valid_in, mac_clr_acc, res_valid, mac_a, mac_b, macc[13:0]};
          en = 1'b0;
        end else if (cyc >= 3 && cyc <= 6) begin
          chk("en_freeze", 32'({busy, mac_valid_in, mac_clr_acc, res_valid, mac_a, mac_b, macc[13:0]}),
              32'(snap));
          if (cyc == 6) en = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; wr_en = 1'b0; en = 1'b1;
    if (t_res < 0) chk("res_valid_timeout", 0, 1);
    chk("clr_pulses", 32'(clr_n), 1);
    chk("valid_in_count", 32'(vin_n), 32'(n));
    if (n == 0) chk("zero_len_latency", 32'(t_res), 1);
    if (mode[2]) chk("drain_timeout_cycles", 32'(t_res - t_drain), TO_CYC);
    r = res_data;
    e = err;
    hold_d = res_data;
    for (int k = 0; k < bp; k++) begin
      start = (mode[0] && k == 1);
      @(negedge clk);
      start = 1'b0;
      chk("bp_res_valid", 32'({res_valid, busy}), 3);
      chk("bp_res_data", res_data, hold_d);
    end
    res_ready = 1'b1;
    start = mode[0];
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    chk("handshake_idle", 32'({busy, res_valid}), 0);
    @(negedge clk);
    chk("handshake_start_ignored", 32'(busy), 0);
  endtask

  typedef struct packed {
    logic [4:0]       n;
    logic [15:0][7:0] a;
    logic [15:0][7:0] b;
    logic [31:0]      exp;
  } vec_t;

  vec_t vt [5];
  logic [31:0] r;
  logic e;

  initial begin
    rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
    start = 1'b0; len = '0; res_ready = 1'b0;

    for (int i = 0; i < 5; i++) vt[i] = '0;
    vt[0].n = 3; vt[0].a[0] = 3; vt[0].a[1] = 10; vt[0].a[2] = 5;
    vt[0].b[0] = 4; vt[0].b[1] = 2; vt[0].b[2] = 5; vt[0].exp = 57;
    vt[1].n = 0; vt[1].exp = 0;
    vt[2].n = 16; vt[2].exp = 1040400;
    for (int i = 0; i < 16; i++) begin vt[2].a[i] = 8'd255; vt[2].b[i] = 8'd255; end
    vt[3].n = 5; vt[3].exp = 30;
    for (int i = 0; i < 5; i++) begin vt[3].a[i] = 8'(i + 1); vt[3].b[i] = 8'd2; end
    vt[4].n = 1; vt[4].a[0] = 8'd200; vt[4].b[0] = 8'd100; vt[4].exp = 20000;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({busy, mac_valid_in, mac_clr_acc, res_valid, err}), 0);
    chk("reset_data", {mac_a, mac_b} | res_data, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 16; i++) wr_one(i, vt[v].a[i], vt[v].b[i]);
      run_cmd(int'(vt[v].n), 0, 0, r, e);
      chk($sformatf("vec%0d_result", v), r, vt[v].exp);
      chk($sformatf("vec%0d_err", v), 32'(e), 0);
    end

    for (int i = 0; i < 16; i++) wr_one(i, vt[0].a[i], vt[0].b[i]);
    run_cmd(3, 1, 5, r, e);
    chk("bp_result", r, 57);
    run_cmd(3, 0, 0, r, e);
    chk("buffer_unchanged", r, 57);

    run_cmd(3, 2, 0, r, e);
    chk("en_stall_result", r, 57);

    run_cmd(3, 4, 2, r, e);
    chk("timeout_err", 32'(e), 1);
    chk("timeout_data", r, ref_dot(3));
    chk("err_sticky_idle", 32'(err), 1);
    drop_last = 1'b0;
    run_cmd(3, 0, 0, r, e);
    chk("post_timeout_result", r, 57);

    for (int t = 0; t < 12; t++) begin
      int n;
      n = int'($urandom_range(0, 16));
      for (int i = 0; i < 16; i++) wr_one(i, 8'($urandom), 8'($urandom));
      run_cmd(n, 0, int'($urandom_range(0, 3)), r, e);
      chk($sformatf("rand%0d_len%0d", t, n), r, ref_dot(n));
      chk($sformatf("rand%0d_err", t), 32'(e), 0);
    end

    start = 1'b1; len = LW'(3);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_issue", 32'({busy, mac_valid_in}), 3);
    rst = 1'b1;
    @(negedge clk);
    chk("midop_reset_outputs", 32'({busy, mac_valid_in, mac_clr_acc, res_valid, err}), 0);
    chk("midop_reset_data", {mac_a, mac_b} | res_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
